// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and hazard controller state encoding.
package cpu_types_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      HALT    = 2'd2
   } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc cycles and sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] MAX_CNT = {W{1'b1}};
   localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

   // Count requested cycles, holding at the top value instead of wrapping
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt <= '0;
      end else if (inc && (cnt != MAX_CNT)) begin
         cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: memory waits, branch flushes,
// load-use bubbles, halt, plus stall and flush performance counters.
module hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dREN,
   input  logic             mem_dWEN,
   input  logic             ex_dREN,
   input  regbits_t         ex_rd,
   input  regbits_t         id_rs,
   input  regbits_t         id_rt,
   input  logic             id_uses_rt,
   input  logic             br_taken,
   input  logic             halt_wb,
   output logic             pipe_ihit,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             idex_freeze,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hz_state_t state, next_state;
   logic      flush_pend, next_flush_pend;
   logic      mem_pend, load_use, flush_req;
   logic      stall_inc, flush_inc;

   // Hazard detection terms feeding the output mux
   always_comb begin
      mem_pend  = (mem_dREN | mem_dWEN) & ~dhit;
      load_use  = ex_dREN && (ex_rd != '0) &&
                  ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
      flush_req = flush_pend | br_taken;
   end

   // State and pending-flush registers; reset clears both immediately
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= RUN;
         flush_pend <= 1'b0;
      end else begin
         state      <= next_state;
         flush_pend <= next_flush_pend;
      end
   end

   // Mealy next-state and latch-control outputs, priority HALT > MEMWAIT > flush > load-use
   always_comb begin
      next_state      = state;
      next_flush_pend = flush_pend;
      pipe_ihit       = 1'b0;
      pc_en           = 1'b0;
      ifid_en         = 1'b0;
      ifid_flush      = 1'b0;
      idex_flush      = 1'b0;
      idex_freeze     = 1'b0;
      exmem_en        = 1'b0;
      memwb_en        = 1'b0;
      halted          = 1'b0;

      case (state)
         HALT: begin
            halted = 1'b1;
         end
         MEMWAIT, RUN: begin
            if ((state == MEMWAIT) && !dhit) begin
               next_state = MEMWAIT;
            end else if ((state == RUN) && mem_pend) begin
               next_state = MEMWAIT;
            end else begin
               next_state = RUN;
               pipe_ihit  = ihit;
               exmem_en   = ihit;
               memwb_en   = ihit;
               if (flush_req) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  pc_en      = ihit;
                  ifid_en    = ihit;
               end else if (load_use) begin
                  idex_freeze = 1'b1;
               end else begin
                  pc_en   = ihit;
                  ifid_en = ihit;
               end
            end

            if (flush_req && pipe_ihit) begin
               next_flush_pend = 1'b0;
            end else if (br_taken && !pipe_ihit) begin
               next_flush_pend = 1'b1;
            end
         end
         default: begin
            next_state = RUN;
         end
      endcase

      if (halt_wb || (state == HALT)) begin
         next_state      = HALT;
         next_flush_pend = 1'b0;
      end

      if (!nRST) begin
         pipe_ihit   = 1'b0;
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b0;
         idex_flush  = 1'b0;
         idex_freeze = 1'b0;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
      end
   end

   // Performance counter increment conditions
   always_comb begin
      stall_inc = (state != HALT) && !pc_en;
      flush_inc = ifid_flush && pipe_ihit;
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK  (CLK),
      .nRST (nRST),
      .inc  (stall_inc),
      .cnt  (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .CLK  (CLK),
      .nRST (nRST),
      .inc  (flush_inc),
      .cnt  (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

   localparam int CNT_W = 16;

   logic             CLK;
   logic             nRST;
   logic             ihit, dhit, mem_dREN, mem_dWEN, ex_dREN;
   logic [4:0]       ex_rd, id_rs, id_rt;
   logic             id_uses_rt, br_taken, halt_wb;
   logic             pipe_ihit, pc_en, ifid_en, ifid_flush, idex_flush;
   logic             idex_freeze, exmem_en, memwb_en, halted;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checkCount = 0;
   int errorCount = 0;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .ihit        (ihit),
      .dhit        (dhit),
      .mem_dREN    (mem_dREN),
      .mem_dWEN    (mem_dWEN),
      .ex_dREN     (ex_dREN),
      .ex_rd       (ex_rd),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .br_taken    (br_taken),
      .halt_wb     (halt_wb),
      .pipe_ihit   (pipe_ihit),
      .pc_en       (pc_en),
      .ifid_en     (ifid_en),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .idex_freeze (idex_freeze),
      .exmem_en    (exmem_en),
      .memwb_en    (memwb_en),
      .halted      (halted),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   // Free-running clock, 10 ns period
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic a_ihit, input logic a_dhit,
                                input logic a_dren, input logic a_dwen,
                                input logic a_exdren, input logic [4:0] a_exrd,
                                input logic [4:0] a_rs, input logic [4:0] a_rt,
                                input logic a_usert, input logic a_br,
                                input logic a_halt);
      ihit       = a_ihit;
      dhit       = a_dhit;
      mem_dREN   = a_dren;
      mem_dWEN   = a_dwen;
      ex_dREN    = a_exdren;
      ex_rd      = a_exrd;
      id_rs      = a_rs;
      id_rt      = a_rt;
      id_uses_rt = a_usert;
      br_taken   = a_br;
      halt_wb    = a_halt;
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Directed scenario sequence
   initial begin
      nRST = 1'b0;
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      checkOutput("rst_pipe_ihit", pipe_ihit, 0);
      checkOutput("rst_pc_en", pc_en, 0);
      checkOutput("rst_stall_cnt", stall_cnt, 0);
      checkOutput("rst_halted", halted, 0);

      tick();
      nRST = 1'b1;
      #1;
      checkOutput("run_pipe_ihit", pipe_ihit, 1);
      checkOutput("run_pc_en", pc_en, 1);
      checkOutput("run_ifid_en", ifid_en, 1);
      checkOutput("run_exmem_en", exmem_en, 1);
      checkOutput("run_memwb_en", memwb_en, 1);
      tick();
      checkOutput("run_stall_cnt", stall_cnt, 0);
      checkOutput("run_flush_cnt", flush_cnt, 0);

      // load-use on rs
      applyStimulus(1, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0);
      checkOutput("lu_freeze", idex_freeze, 1);
      checkOutput("lu_pc_en", pc_en, 0);
      checkOutput("lu_ifid_en", ifid_en, 0);
      checkOutput("lu_exmem_en", exmem_en, 1);
      tick();
      checkOutput("lu_stall_cnt", stall_cnt, 1);
      // ex_rd zero never hazards
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("lu_r0_freeze", idex_freeze, 0);
      checkOutput("lu_r0_pc_en", pc_en, 1);
      // rt path only when the instruction reads rt
      applyStimulus(1, 0, 0, 0, 1, 7, 3, 7, 1, 0, 0);
      checkOutput("lu_rt_freeze", idex_freeze, 1);
      applyStimulus(1, 0, 0, 0, 1, 7, 3, 7, 0, 0, 0);
      checkOutput("lu_rt_unused_freeze", idex_freeze, 0);
      tick();
      checkOutput("lu_stall_cnt2", stall_cnt, 1);

      // memory wait with a branch arriving during MEMWAIT
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mw1_pipe_ihit", pipe_ihit, 0);
      checkOutput("mw1_pc_en", pc_en, 0);
      tick();
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("mw2_pipe_ihit", pipe_ihit, 0);
      checkOutput("mw2_ifid_flush", ifid_flush, 0);
      tick();
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mw3_pipe_ihit", pipe_ihit, 0);
      tick();
      checkOutput("mw_stall_cnt", stall_cnt, 4);
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mwx_pipe_ihit", pipe_ihit, 1);
      checkOutput("mwx_ifid_flush", ifid_flush, 1);
      checkOutput("mwx_idex_flush", idex_flush, 1);
      checkOutput("mwx_pc_en", pc_en, 1);
      tick();
      checkOutput("mwx_flush_cnt", flush_cnt, 1);
      checkOutput("mwx_stall_cnt", stall_cnt, 4);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mwp_ifid_flush", ifid_flush, 0);
      checkOutput("mwp_pipe_ihit", pipe_ihit, 1);

      // branch without ihit is held pending and issued on the next ihit
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("bp_ifid_flush", ifid_flush, 1);
      checkOutput("bp_pipe_ihit", pipe_ihit, 0);
      tick();
      checkOutput("bp_stall_cnt", stall_cnt, 5);
      checkOutput("bp_flush_cnt", flush_cnt, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("bp2_ifid_flush", ifid_flush, 1);
      checkOutput("bp2_pipe_ihit", pipe_ihit, 1);
      tick();
      checkOutput("bp2_flush_cnt", flush_cnt, 2);

      // branch beats load-use
      applyStimulus(1, 0, 0, 0, 1, 5, 5, 0, 0, 1, 0);
      checkOutput("blu_idex_flush", idex_flush, 1);
      checkOutput("blu_freeze", idex_freeze, 0);
      checkOutput("blu_pc_en", pc_en, 1);
      tick();
      checkOutput("blu_flush_cnt", flush_cnt, 3);
      checkOutput("blu_stall_cnt", stall_cnt, 5);

      // halt takes effect from the next edge and ignores everything after
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("h0_halted", halted, 0);
      checkOutput("h0_pipe_ihit", pipe_ihit, 1);
      tick();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("h1_halted", halted, 1);
      checkOutput("h1_pipe_ihit", pipe_ihit, 0);
      checkOutput("h1_pc_en", pc_en, 0);
      checkOutput("h1_ifid_flush", ifid_flush, 0);
      checkOutput("h1_memwb_en", memwb_en, 0);
      tick();
      checkOutput("h2_halted", halted, 1);
      checkOutput("h2_stall_cnt", stall_cnt, 5);
      checkOutput("h2_flush_cnt", flush_cnt, 3);

      // saturation: 2^16+3 stall cycles from a fresh reset
      nRST = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("sat_rst_halted", halted, 0);
      checkOutput("sat_rst_stall_cnt", stall_cnt, 0);
      nRST = 1'b1;
      repeat (65534) @(posedge CLK);
      #1;
      checkOutput("sat_pre_stall_cnt", stall_cnt, 65534);
      repeat (5) @(posedge CLK);
      #1;
      checkOutput("sat_stall_cnt", stall_cnt, 65535);

      // reset in MEMWAIT with a pending flush clears everything asynchronously
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      nRST = 1'b0;
      #1;
      checkOutput("ar_stall_cnt", stall_cnt, 0);
      checkOutput("ar_flush_cnt", flush_cnt, 0);
      checkOutput("ar_pipe_ihit", pipe_ihit, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nRST = 1'b1;
      #1;
      checkOutput("ar_run_pipe_ihit", pipe_ihit, 1);
      checkOutput("ar_ifid_flush", ifid_flush, 0);
      tick();
      checkOutput("ar_flush_cnt2", flush_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
